key_event_ctrl: RTL and testbench
=================================

# key_event_ctrl

Event controller that sits between the 4x4 keypad scanner and the CPU-visible confreg port. It samples the scanner's active-low 16-bit key status, turns press/release transitions into encoded key events, and buffers them in a small FIFO. Software drains the FIFO through a valid/ready handshake. An optional auto-repeat feature emits repeat presses while a key is held.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; power of 2, minimum 2.
- REPEAT_DELAY, 24'd5_000_000: cycles from press to first repeat (KEY_REPEAT_EN only).
- REPEAT_PERIOD, 24'd1_000_000: cycles between subsequent repeats (KEY_REPEAT_EN only).

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- key_info  in  16  scanner status, active-low; bit i low means key i pressed
- evt_valid  out  1  FIFO non-empty; evt_data valid
- evt_ready  in  1  consumer accepts head entry
- evt_data  out  8  [7] 1=press, 0=release; [6] repeat flag; [5:4] 0; [3:0] key index
- evt_count  out  $clog2(DEPTH)+1  number of entries held
- overflow  out  1  sticky; an event was dropped because the FIFO was full
- clear  in  1  synchronous flush of FIFO and overflow

## Operation
- key_info is registered once into key_q. Decode: `single` = exactly one bit of key_q low; `none` = all bits high; `idx` = index of the low bit.
- Any pattern with two or more bits low is ignored, and the FSM holds its state.
- FSM states:
  - IDLE: `single` -> push press(idx), latch cur = idx, go to HELD.
  - HELD: `none` -> push release(cur), go to IDLE. `single` with idx != cur -> push release(cur), latch nxt = idx, go to SWAP. Same key -> stay in HELD.
  - SWAP: push press(nxt), cur = nxt, go to HELD. This happens unconditionally, one cycle after the release.
- FIFO push on the FSM push strobe; pop when evt_valid && evt_ready.
- Push while full and not popping: the event is dropped and overflow is set. Push and pop in the same cycle while full: both happen, no overflow.
- Pop while empty: no effect.
- clear: the FIFO empties and overflow is cleared on the next edge. Clear takes priority over a same-cycle push or pop, and the pushed event is discarded. The FSM and cur are unaffected.
- Reset values:
  - evt_valid = 0, evt_data = 8'h00, evt_count = 0, overflow = 0
  - FSM = IDLE, cur = 0, key_q = 16'hFFFF
  - pointers = 0, repeat counter = 0

## Timing
- Latency: a key_info change just before edge N is seen in key_q after edge N. The event is written at edge N+1, so evt_valid is high after edge N+1 when the FIFO was empty.
- A key swap yields the release after edge N+1 and the press after edge N+2.
- evt_data is driven combinationally from the head entry; it is stable while evt_valid is high and not popped.
- evt_count updates on the same edge as push/pop.
- When resetn is asserted mid-operation, all state clears immediately (asynchronously). Any held key reports a fresh press after release of reset, with the standard 2-cycle latency.

## Configuration
- KEY_REPEAT_EN defined:
  - In HELD, a 24-bit counter runs. At REPEAT_DELAY it pushes press(cur) with bit6 = 1 and reloads to REPEAT_PERIOD.
  - The counter clears on entry to HELD and on any exit from HELD.
  - A repeat push that coincides with a full FIFO is dropped and sets overflow.
- KEY_REPEAT_EN undefined: no counter is built, bit6 is always 0, and the REPEAT_* parameters are unused.

## Structure
- Package key_pkg:
  - EVT_W = 8
  - field positions EVT_PRESS_BIT = 7, EVT_REPEAT_BIT = 6
  - FSM state encoding (IDLE = 2'd0, HELD = 2'd1, SWAP = 2'd2)
  - KEY_NONE = 16'hFFFF
- One sub-module, key_evt_fifo: synchronous DEPTH x EVT_W FIFO with push/pop/flush, count and full/empty outputs. Decode and FSM live in key_event_ctrl.

## Test plan
- Press key 5 (key_info = 16'hFFDF), hold, then release -> evt_data 8'h85 appears 2 cycles after the change, then 8'h05 after the release; evt_count sequence 1 -> 0 with evt_ready = 1.
- Hold key 3, then switch directly to key 12 -> two events on consecutive cycles: 8'h03, 8'h8C.
- evt_ready = 0; generate 5 press/release events with DEPTH = 4 -> evt_count = 4, overflow = 1, and the first 4 events are retained in order. Pulse clear -> evt_count = 0, overflow = 0.
- Full FIFO with a push and pop in the same cycle -> evt_count stays 4, overflow stays 0, and the new event appears at the tail.
- key_info = 16'hFFFC (two keys) from IDLE -> no event; then 16'hFFFE -> 8'h80.
- KEY_REPEAT_EN, REPEAT_DELAY = 10, REPEAT_PERIOD = 4, key 0 held 20 cycles -> 8'h80, then 8'hC0 at 10 cycles after the press and every 4 cycles thereafter; release gives 8'h00 and no further repeats.

Source files
------------

// File: rtl/key_pkg.sv
// Shared types and constants for the keypad event controller.
package key_pkg;

    localparam int unsigned EVT_W          = 8;
    localparam int unsigned EVT_PRESS_BIT  = 7;
    localparam int unsigned EVT_REPEAT_BIT = 6;
    localparam int unsigned KEY_W          = 16;
    localparam int unsigned IDX_W          = 4;

    localparam logic [KEY_W-1:0] KEY_NONE = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        SWAP = 2'd2
    } key_state_t;

    typedef struct packed {
        logic             press;
        logic             rpt;
        logic [1:0]       rsvd;
        logic [IDX_W-1:0] idx;
    } key_evt_t;

    // Assemble an event word from its fields; reserved bits stay zero.
    function automatic key_evt_t mk_evt(input logic press, input logic rpt,
                                        input logic [IDX_W-1:0] idx);
        logic [EVT_W-1:0] e;
        e                 = '0;
        e[EVT_PRESS_BIT]  = press;
        e[EVT_REPEAT_BIT] = rpt;
        e[IDX_W-1:0]      = idx;
        return key_evt_t'(e);
    endfunction

endpackage

// File: rtl/key_evt_fifo.sv
// Synchronous DEPTH-entry event FIFO with flush; head entry is shown combinationally.
module key_evt_fifo
    import key_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  key_evt_t                 push_data,
    input  logic                     pop,
    input  logic                     flush,
    output key_evt_t                 rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    key_evt_t          mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= PTR_W'(wr_ptr + PTR_W'(1));
            end
            if (do_pop) rd_ptr <= PTR_W'(rd_ptr + PTR_W'(1));
            case ({do_push, do_pop})
                2'b10:   count <= CNT_W'(count + CNT_W'(1));
                2'b01:   count <= CNT_W'(count - CNT_W'(1));
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/key_event_ctrl.sv
// Keypad press/release event generator feeding a drainable event FIFO.
// Optional auto-repeat while a key is held: define KEY_REPEAT_EN.
module key_event_ctrl
    import key_pkg::*;
#(
    parameter int unsigned DEPTH         = 4,
    parameter logic [23:0] REPEAT_DELAY  = 24'd5_000_000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd1_000_000
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic [KEY_W-1:0]         key_info,
    output logic                     evt_valid,
    input  logic                     evt_ready,
    output logic [EVT_W-1:0]         evt_data,
    output logic [$clog2(DEPTH):0]   evt_count,
    output logic                     overflow,
    input  logic                     clear
);

    key_state_t        state, state_n;
    logic [KEY_W-1:0]  key_q;
    logic [KEY_W-1:0]  key_low;
    logic              key_single;
    logic              key_none;
    logic [IDX_W-1:0]  key_idx;
    logic [IDX_W-1:0]  cur, cur_n;
    logic [IDX_W-1:0]  nxt, nxt_n;
    logic              push_c;
    key_evt_t          push_evt;
    logic              pop_c;
    logic              rpt_fire_c;
    logic              fifo_full;
    logic              fifo_empty;
    key_evt_t          fifo_head;

    // Key status decode: exactly one pressed key, or none at all.
    always_comb begin
        key_low    = ~key_q;
        key_single = $onehot(key_low);
        key_none   = (key_q == KEY_NONE);
        key_idx    = '0;
        for (int i = 0; i < KEY_W; i++) begin
            if (key_low[i]) key_idx = IDX_W'(i);
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            key_q <= KEY_NONE;
            state <= IDLE;
            cur   <= '0;
            nxt   <= '0;
        end else begin
            key_q <= key_info;
            state <= state_n;
            cur   <= cur_n;
            nxt   <= nxt_n;
        end
    end

    // Next state and push strobe; multi-key patterns fall through and hold state.
    always_comb begin
        state_n  = state;
        cur_n    = cur;
        nxt_n    = nxt;
        push_c   = 1'b0;
        push_evt = mk_evt(1'b0, 1'b0, cur);
        case (state)
            IDLE: begin
                if (key_single) begin
                    push_c   = 1'b1;
                    push_evt = mk_evt(1'b1, 1'b0, key_idx);
                    cur_n    = key_idx;
                    state_n  = HELD;
                end
            end
            HELD: begin
                if (key_none) begin
                    push_c   = 1'b1;
                    push_evt = mk_evt(1'b0, 1'b0, cur);
                    state_n  = IDLE;
                end else if (key_single && (key_idx != cur)) begin
                    push_c   = 1'b1;
                    push_evt = mk_evt(1'b0, 1'b0, cur);
                    nxt_n    = key_idx;
                    state_n  = SWAP;
                end else if (rpt_fire_c) begin
                    push_c   = 1'b1;
                    push_evt = mk_evt(1'b1, 1'b1, cur);
                end
            end
            SWAP: begin
                push_c   = 1'b1;
                push_evt = mk_evt(1'b1, 1'b0, nxt);
                cur_n    = nxt;
                state_n  = HELD;
            end
            default: state_n = IDLE;
        endcase
    end

`ifdef KEY_REPEAT_EN
    logic [23:0] rpt_cnt;
    logic        rpt_first;
    logic [23:0] rpt_limit;

    // First repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
    assign rpt_limit  = rpt_first ? REPEAT_DELAY : REPEAT_PERIOD;
    assign rpt_fire_c = (state == HELD) && (24'(rpt_cnt + 24'd1) == rpt_limit);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if ((state != HELD) || (state_n != HELD)) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
        end else if (rpt_fire_c) begin
            rpt_cnt   <= '0;
            rpt_first <= 1'b0;
        end else begin
            rpt_cnt   <= 24'(rpt_cnt + 24'd1);
        end
    end
`else
    logic unused_rpt_params;

    assign rpt_fire_c        = 1'b0;
    assign unused_rpt_params = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

    assign evt_valid = !fifo_empty;
    assign pop_c     = evt_valid && evt_ready;
    assign evt_data  = fifo_head;

    // Sticky drop flag; a same-cycle pop makes room so nothing is lost.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow <= 1'b0;
        end else if (clear) begin
            overflow <= 1'b0;
        end else if (push_c && fifo_full && !pop_c) begin
            overflow <= 1'b1;
        end
    end

    key_evt_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push_c),
        .push_data (push_evt),
        .pop       (pop_c),
        .flush     (clear),
        .rd_data   (fifo_head),
        .count     (evt_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_key_event_ctrl.sv
// Directed bench for key_event_ctrl: vector table plus multi-cycle FIFO/reset sequences.
module tb_key_event_ctrl;

    logic        clk = 1'b0;
    logic        resetn;
    logic [15:0] key_info;
    logic        evt_valid;
    logic        evt_ready;
    logic [7:0]  evt_data;
    logic [2:0]  evt_count;
    logic        overflow;
    logic        clear;

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic [15:0] key;
        logic        rdy;
        logic        exp_valid;
        logic [7:0]  exp_data;
        logic [2:0]  exp_cnt;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs [26];

    key_event_ctrl #(
        .DEPTH         (4),
        .REPEAT_DELAY  (24'd10),
        .REPEAT_PERIOD (24'd4)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .key_info  (key_info),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_data  (evt_data),
        .evt_count (evt_count),
        .overflow  (overflow),
        .clear     (clear)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic set_key(input logic [15:0] k, input int n);
        key_info = k;
        repeat (n) step();
    endtask

    task automatic pop_expect(input string name, input logic [7:0] d);
        chk({name, "_valid"}, 32'(evt_valid), 32'd1);
        chk({name, "_data"}, 32'(evt_data), 32'(d));
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
    endtask

    function automatic vec_t mkv(input logic [15:0] k, input logic r, input logic v,
                                 input logic [7:0] d, input logic [2:0] c);
        vec_t x;
        x.key = k; x.rdy = r; x.exp_valid = v; x.exp_data = d; x.exp_cnt = c; x.exp_ovf = 1'b0;
        return x;
    endfunction

    initial begin
        // press/release key 5
        vecs[0]  = mkv(16'hFFDF, 1, 0, 8'h00, 3'd0);
        vecs[1]  = mkv(16'hFFDF, 1, 1, 8'h85, 3'd1);
        vecs[2]  = mkv(16'hFFDF, 1, 0, 8'h00, 3'd0);
        vecs[3]  = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);
        vecs[4]  = mkv(16'hFFFF, 1, 1, 8'h05, 3'd1);
        vecs[5]  = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);
        // key 3 then direct swap to key 12
        vecs[6]  = mkv(16'hFFF7, 1, 0, 8'h00, 3'd0);
        vecs[7]  = mkv(16'hFFF7, 1, 1, 8'h83, 3'd1);
        vecs[8]  = mkv(16'hFFF7, 1, 0, 8'h00, 3'd0);
        vecs[9]  = mkv(16'hEFFF, 1, 0, 8'h00, 3'd0);
        vecs[10] = mkv(16'hEFFF, 1, 1, 8'h03, 3'd1);
        vecs[11] = mkv(16'hEFFF, 1, 1, 8'h8C, 3'd1);
        vecs[12] = mkv(16'hEFFF, 1, 0, 8'h00, 3'd0);
        vecs[13] = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);
        vecs[14] = mkv(16'hFFFF, 1, 1, 8'h0C, 3'd1);
        vecs[15] = mkv(16'hFFFF, 0, 1, 8'h0C, 3'd1);
        vecs[16] = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);
        // two keys ignored, then a single key
        vecs[17] = mkv(16'hFFFC, 1, 0, 8'h00, 3'd0);
        vecs[18] = mkv(16'hFFFC, 1, 0, 8'h00, 3'd0);
        vecs[19] = mkv(16'hFFFC, 1, 0, 8'h00, 3'd0);
        vecs[20] = mkv(16'hFFFE, 1, 0, 8'h00, 3'd0);
        vecs[21] = mkv(16'hFFFE, 1, 1, 8'h80, 3'd1);
        vecs[22] = mkv(16'hFFFE, 1, 0, 8'h00, 3'd0);
        vecs[23] = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);
        vecs[24] = mkv(16'hFFFF, 1, 1, 8'h00, 3'd1);
        vecs[25] = mkv(16'hFFFF, 1, 0, 8'h00, 3'd0);

        resetn    = 1'b0;
        key_info  = 16'hFFFF;
        evt_ready = 1'b0;
        clear     = 1'b0;
        repeat (2) step();
        chk("rst_valid", 32'(evt_valid), 32'd0);
        chk("rst_data",  32'(evt_data),  32'h00);
        chk("rst_count", 32'(evt_count), 32'd0);
        chk("rst_ovf",   32'(overflow),  32'd0);
        resetn = 1'b1;

        for (int i = 0; i < 26; i++) begin
            key_info  = vecs[i].key;
            evt_ready = vecs[i].rdy;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_count", i), 32'(evt_count), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_ovf", i),   32'(overflow),  32'(vecs[i].exp_ovf));
            if (vecs[i].exp_valid)
                chk($sformatf("vec%0d_data", i), 32'(evt_data), 32'(vecs[i].exp_data));
        end

        // Overflow: five events into four entries, first four kept in order.
        evt_ready = 1'b0;
        set_key(16'hFFFD, 3);
        set_key(16'hFFFF, 3);
        set_key(16'hFFFB, 3);
        set_key(16'hFFFF, 3);
        set_key(16'hFFF7, 3);
        chk("ovf_count", 32'(evt_count), 32'd4);
        chk("ovf_flag",  32'(overflow),  32'd1);
        pop_expect("ovf_e0", 8'h81);
        pop_expect("ovf_e1", 8'h01);
        pop_expect("ovf_e2", 8'h82);
        pop_expect("ovf_e3", 8'h02);
        chk("ovf_drained", 32'(evt_count), 32'd0);
        chk("ovf_sticky",  32'(overflow),  32'd1);

        // Refill, then clear flushes entries and the sticky flag.
        set_key(16'hFFFF, 3);
        set_key(16'hFFEF, 3);
        set_key(16'hFFFF, 3);
        set_key(16'hFFDF, 3);
        chk("refill_count", 32'(evt_count), 32'd4);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clr_count", 32'(evt_count), 32'd0);
        chk("clr_ovf",   32'(overflow),  32'd0);
        chk("clr_valid", 32'(evt_valid), 32'd0);

        // Full FIFO: push and pop in the same cycle.
        set_key(16'hFFFF, 3);
        set_key(16'hFFBF, 3);
        set_key(16'hFFFF, 3);
        set_key(16'hFF7F, 3);
        chk("pp_full", 32'(evt_count), 32'd4);
        key_info = 16'hFFFF;
        step();
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("pp_count", 32'(evt_count), 32'd4);
        chk("pp_ovf",   32'(overflow),  32'd0);
        pop_expect("pp_e0", 8'h86);
        pop_expect("pp_e1", 8'h06);
        pop_expect("pp_e2", 8'h87);
        pop_expect("pp_tail", 8'h07);

        // Clear wins over a same-cycle push.
        key_info = 16'hFEFF;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clrpush_count", 32'(evt_count), 32'd0);
        step();
        chk("clrpush_after", 32'(evt_count), 32'd0);

        // Asynchronous reset mid-operation, held key reports a fresh press.
        set_key(16'hFFFF, 3);
        chk("pre_rst_count", 32'(evt_count), 32'd1);
        key_info = 16'hFEFF;
        step();
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 32'd0);
        chk("arst_count", 32'(evt_count), 32'd0);
        chk("arst_data",  32'(evt_data),  32'h00);
        step();
        resetn = 1'b1;
        step();
        chk("post_rst_lat", 32'(evt_valid), 32'd0);
        step();
        chk("post_rst_valid", 32'(evt_valid), 32'd1);
        chk("post_rst_data",  32'(evt_data),  32'h88);

        // Drain and return to idle.
        evt_ready = 1'b1;
        set_key(16'hFFFF, 4);
        chk("idle_count", 32'(evt_count), 32'd0);

`ifdef KEY_REPEAT_EN
        // Auto-repeat: press at c=2, repeats at c=12,16,20, release at c=22.
        key_info = 16'hFFFE;
        for (int c = 1; c <= 30; c++) begin
            logic       ev;
            logic [7:0] ed;
            step();
            ev = 1'b1;
            ed = 8'hC0;
            case (c)
                2:          ed = 8'h80;
                12, 16, 20: ed = 8'hC0;
                22:         ed = 8'h00;
                default:    ev = 1'b0;
            endcase
            chk($sformatf("rpt_c%0d_valid", c), 32'(evt_valid), 32'(ev));
            if (ev) chk($sformatf("rpt_c%0d_data", c), 32'(evt_data), 32'(ed));
            if (c == 20) key_info = 16'hFFFF;
        end
        chk("rpt_ovf", 32'(overflow), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
